// File: rtl/hwpe_ctrl_reqrsp_mctx.sv
// rtl/hwpe_ctrl_reqrsp_mctx.sv - multi-context push/pull reqrsp control slave with FIFO job issue
module hwpe_ctrl_reqrsp_mctx #(
  parameter int unsigned N_CTX       = 2,
  parameter int unsigned NB_REGISTER = 16,
  parameter int unsigned DATA_WIDTH  = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  output logic                              clear_o,
  input  logic                              req_valid_i,
  input  logic                              req_write_i,
  input  logic [4:0]                        req_addr_i,
  input  logic [DATA_WIDTH-1:0]             req_data_i,
  output logic                              req_ready_o,
  output logic                              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]             rsp_data_o,
  input  logic                              done_i,
  output logic                              start_o,
  output logic                              done_o,
  output logic                              busy_o,
  output logic [$clog2(N_CTX)-1:0]          running_ctx_o,
  output logic [NB_REGISTER*DATA_WIDTH-1:0] regfile_o
);

  localparam int unsigned PW = $clog2(N_CTX);
  localparam int unsigned RW = $clog2(NB_REGISTER);
  localparam int unsigned CW = $clog2(N_CTX + 1);

  typedef enum logic [1:0] {IDLE, START, RUN} state_e;
  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] ctx_q [N_CTX][NB_REGISTER];
  logic [15:0]           job_id_q [N_CTX];
  logic [PW-1:0]         wp_q, rp_q;
  logic [CW-1:0]         cnt_q;
  logic [RW-1:0]         push_ptr_q, pull_ptr_q;
  logic [15:0]           next_id_q, last_id_q;
  logic                  locked_q, done_q, rsp_valid_q;
  logic [1:0]            clr_q;
  logic [DATA_WIDTH-1:0] rsp_data_q, rd_data, status;

  logic [2:0] idx;
  logic       rd, wr, trig, push, pull, acq, acq_ok, clr_full, clr_part, clr_sync, job_done;
  logic       unused_addr;

  assign unused_addr = ^req_addr_i[1:0];
  assign idx      = req_addr_i[4:2];
  assign clear_o  = (clr_q != 2'd0);
  assign req_ready_o = ~clear_o;
  assign rd       = req_valid_i & req_ready_o & ~req_write_i;
  assign wr       = req_valid_i & req_ready_o & req_write_i;
  assign trig     = wr & (idx == 3'd0) & locked_q;
  assign push     = wr & (idx == 3'd4) & locked_q;
  assign clr_full = wr & (idx == 3'd3) & (req_data_i == '0);
  assign clr_part = wr & (idx == 3'd3) & (req_data_i != '0);
  assign pull     = rd & (idx == 3'd5);
  assign acq      = rd & (idx == 3'd6);
  assign acq_ok   = (cnt_q != CW'(N_CTX)) | locked_q;
  // Clear acts from the SOFTCLR edge onward so nothing (incl. done_o) leaks out during the pulse
  assign clr_sync = clr_full | clear_o;
  assign job_done = (state_q == RUN) & done_i;

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign done_o        = done_q;
  assign running_ctx_o = rp_q;

  always_comb begin
    for (int unsigned r = 0; r < NB_REGISTER; r++) begin
      regfile_o[r*DATA_WIDTH +: DATA_WIDTH] = ctx_q[rp_q][r];
    end
  end

  always_comb begin
    status         = '0;
    status[0]      = busy_o;
    status[1]      = locked_q;
    status[8 +: CW] = cnt_q;
    status[16 +: 16] = last_id_q;
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      3'd1: rd_data = status;
      3'd2: rd_data[15:0] = job_id_q[wp_q - PW'(1)];
      3'd5: rd_data = ctx_q[rp_q][pull_ptr_q];
      3'd6: begin
        if (acq_ok) rd_data[PW-1:0] = wp_q;
        else        rd_data = '1;
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clr_q <= 2'd0;
    end else if (clr_full) begin
      clr_q <= 2'd2;
    end else if (clear_o) begin
      clr_q <= clr_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < N_CTX; c++) begin
        job_id_q[c] <= '0;
        for (int unsigned r = 0; r < NB_REGISTER; r++) ctx_q[c][r] <= '0;
      end
      wp_q <= '0; rp_q <= '0; cnt_q <= '0; locked_q <= 1'b0;
      push_ptr_q <= '0; pull_ptr_q <= '0; next_id_q <= '0; last_id_q <= '0;
      done_q <= 1'b0; rsp_valid_q <= 1'b0; rsp_data_q <= '0;
    end else if (clr_sync) begin
      for (int unsigned c = 0; c < N_CTX; c++) begin
        job_id_q[c] <= '0;
        for (int unsigned r = 0; r < NB_REGISTER; r++) ctx_q[c][r] <= '0;
      end
      wp_q <= '0; rp_q <= '0; cnt_q <= '0; locked_q <= 1'b0;
      push_ptr_q <= '0; pull_ptr_q <= '0; next_id_q <= '0; last_id_q <= '0;
      done_q <= 1'b0; rsp_valid_q <= 1'b0; rsp_data_q <= '0;
    end else begin
      rsp_valid_q <= rd;
      if (rd) rsp_data_q <= rd_data;
      if (acq && acq_ok) locked_q <= 1'b1;
      if (push) begin
        ctx_q[wp_q][push_ptr_q] <= req_data_i;
        push_ptr_q <= push_ptr_q + RW'(1);
      end
      if (clr_part) begin
        for (int unsigned r = 0; r < NB_REGISTER; r++) ctx_q[wp_q][r] <= '0;
        push_ptr_q <= '0;
      end
      if (trig) begin
        job_id_q[wp_q] <= next_id_q;
        next_id_q  <= next_id_q + 16'd1;
        wp_q       <= wp_q + PW'(1);
        locked_q   <= 1'b0;
        push_ptr_q <= '0;
      end
      if (trig && !job_done)      cnt_q <= cnt_q + CW'(1);
      else if (!trig && job_done) cnt_q <= cnt_q - CW'(1);
      if (job_done) begin
        rp_q      <= rp_q + PW'(1);
        last_id_q <= job_id_q[rp_q];
      end
      done_q <= job_done;
      if (state_q == START) pull_ptr_q <= '0;
      else if (pull)        pull_ptr_q <= pull_ptr_q + RW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       state_q <= IDLE;
    else if (clr_sync) state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt_q != '0) state_d = START;
      START:   state_d = RUN;
      RUN:     if (done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_o = (state_q == START);
    busy_o  = (state_q == RUN);
  end

endmodule

// File: tb/tb_hwpe_ctrl_reqrsp_mctx.sv
// tb/tb_hwpe_ctrl_reqrsp_mctx.sv - directed self-checking bench for hwpe_ctrl_reqrsp_mctx
module tb_hwpe_ctrl_reqrsp_mctx;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          req_valid, req_write, req_ready;
  logic [4:0]    req_addr;
  logic [63:0]   req_data;
  logic          rsp_valid;
  logic [63:0]   rsp_data;
  logic          done_in, start, done_out, busy;
  logic [0:0]    running_ctx;
  logic [1023:0] regfile;
  logic [63:0]   d;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  hwpe_ctrl_reqrsp_mctx #(.N_CTX(2), .NB_REGISTER(16), .DATA_WIDTH(64)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_o       (clear),
    .req_valid_i   (req_valid),
    .req_write_i   (req_write),
    .req_addr_i    (req_addr),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .rsp_valid_o   (rsp_valid),
    .rsp_data_o    (rsp_data),
    .done_i        (done_in),
    .start_o       (start),
    .done_o        (done_out),
    .busy_o        (busy),
    .running_ctx_o (running_ctx),
    .regfile_o     (regfile)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input int idx, input logic [63:0] data);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = {idx[2:0], 2'b00}; req_data = data;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic rdreg(input int idx, output logic [63:0] data);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = {idx[2:0], 2'b00};
    @(negedge clk);
    req_valid = 1'b0;
    check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
    data = rsp_data;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
  endtask

  function automatic logic [63:0] reg_of(input int r);
    return regfile[r*64 +: 64];
  endfunction

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0; done_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_clear", {63'd0, clear}, 64'd0);
    check("rst_start", {63'd0, start}, 64'd0);
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_done",  {63'd0, done_out}, 64'd0);
    check("rst_rspv",  {63'd0, rsp_valid}, 64'd0);
    check("rst_reg0",  reg_of(0), 64'd0);

    wr(4, 64'hDEAD);
    check("push_unlocked", reg_of(0), 64'd0);
    check("wr_no_rsp", {63'd0, rsp_valid}, 64'd0);

    rdreg(6, d); check("acq_first", d, 64'd0);
    wr(4, 64'hA); wr(4, 64'hB); wr(0, 64'd0);
    check("start_pre", {63'd0, start}, 64'd0);
    tick(); check("start_1", {63'd0, start}, 64'd1);
    tick();
    check("start_end", {63'd0, start}, 64'd0);
    check("busy_run", {63'd0, busy}, 64'd1);
    check("job0_reg0", reg_of(0), 64'hA);
    check("job0_reg1", reg_of(1), 64'hB);
    check("job0_ctx", {63'd0, running_ctx}, 64'd0);

    rdreg(6, d); check("acq_second", d, 64'd1);
    wr(4, 64'h11); wr(0, 64'd0);
    rdreg(6, d); check("acq_full", d, 64'hFFFF_FFFF_FFFF_FFFF);
    rdreg(2, d); check("jobid_2trig", d, 64'd1);
    rdreg(1, d); check("status_full", d, 64'h201);

    pulse_done();
    check("done_o", {63'd0, done_out}, 64'd1);
    check("start_gap", {63'd0, start}, 64'd0);
    check("rp_adv", {63'd0, running_ctx}, 64'd1);
    tick();
    check("start_b2b", {63'd0, start}, 64'd1);
    check("done_once", {63'd0, done_out}, 64'd0);
    check("job1_reg0", reg_of(0), 64'h11);
    rdreg(6, d); check("acq_after_done", d, 64'd0);

    for (int i = 0; i <= 16; i++) wr(4, 64'h100 + 64'(i));
    wr(0, 64'd0);
    rdreg(2, d); check("jobid_3trig", d, 64'd2);
    pulse_done();
    tick();
    check("start_job2", {63'd0, start}, 64'd1);
    rdreg(1, d); check("status_2done", d, 64'h1_0101);
    check("wrap_reg0", reg_of(0), 64'h110);
    check("wrap_reg1", reg_of(1), 64'h101);
    check("wrap_reg15", reg_of(15), 64'h10F);

    rdreg(6, d); check("acq_simul", d, 64'd1);
    wr(4, 64'h222);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd0; req_data = '0; done_in = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; done_in = 1'b0;
    check("simul_done", {63'd0, done_out}, 64'd1);
    tick();
    check("simul_start", {63'd0, start}, 64'd1);
    rdreg(1, d); check("simul_status", d, 64'h2_0101);
    check("simul_reg0", reg_of(0), 64'h222);
    check("simul_ctx", {63'd0, running_ctx}, 64'd1);

    rdreg(6, d); check("acq_preclr", d, 64'd0);
    wr(3, 64'd0);
    check("clr_1", {63'd0, clear}, 64'd1);
    check("clr_ready_1", {63'd0, req_ready}, 64'd0);
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    check("clr_2", {63'd0, clear}, 64'd1);
    check("clr_ready_2", {63'd0, req_ready}, 64'd0);
    check("clr_no_done", {63'd0, done_out}, 64'd0);
    tick();
    check("clr_end", {63'd0, clear}, 64'd0);
    check("clr_ready_end", {63'd0, req_ready}, 64'd1);
    check("clr_no_done2", {63'd0, done_out}, 64'd0);
    check("clr_busy", {63'd0, busy}, 64'd0);
    rdreg(1, d); check("clr_status", d, 64'd0);
    rdreg(2, d); check("clr_jobid", d, 64'd0);
    check("clr_reg0", reg_of(0), 64'd0);
    check("clr_ctx", {63'd0, running_ctx}, 64'd0);

    rdreg(6, d); check("acq_postclr", d, 64'd0);
    wr(4, 64'h55); wr(4, 64'h66);
    check("pre_part_reg0", reg_of(0), 64'h55);
    check("pre_part_reg1", reg_of(1), 64'h66);
    wr(3, 64'd5);
    check("part_no_clear", {63'd0, clear}, 64'd0);
    check("part_reg0", reg_of(0), 64'd0);
    check("part_reg1", reg_of(1), 64'd0);
    wr(4, 64'h77);
    check("part_push_reg0", reg_of(0), 64'h77);
    check("part_push_reg1", reg_of(1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
